// File: rtl/ex_exception_stage.sv
// EX->MEM exception slice: merges ID-carried exception flags with EX-detected
// overflow and data address errors, resolves the single winning cause, and
// registers the bundle for the MEM-stage exception unit. After an excepting
// (or ERET) instruction is handed over, younger instructions are discarded
// until MEM flushes the pipeline. Data-SRAM requests are suppressed for
// excepting, killed or flushed instructions.
module ex_exception_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_bd,
    input  logic        in_exc_fetch,
    input  logic        in_ri,
    input  logic        in_sys,
    input  logic        in_bp,
    input  logic        in_eret,
    input  logic        in_mtc0,
    input  logic        in_mfc0,
    input  logic [4:0]  in_cp0_addr,
    input  logic        in_detect_of,
    input  logic        in_alu_of,
    input  logic        in_mem_rd,
    input  logic        in_mem_wr,
    input  logic [1:0]  in_mem_size,
    input  logic [31:0] in_mem_addr,
    output logic        mem_req_ok,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_bd,
    output logic        out_eret,
    output logic        out_set_cp0,
    output logic        out_read_cp0,
    output logic [4:0]  out_cp0_addr,
    output logic [31:0] out_badaddr,
    output logic        out_exc_fetch,
    output logic        out_exc_reserved,
    output logic        out_exc_instruction,
    output logic        out_exc_data,
    output logic        out_adel,
    output logic        out_ades,
    output logic        out_sys,
    output logic        out_bp,
    output logic        out_ri,
    output logic        out_ov,
    output logic [4:0]  out_exccode
);

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
        logic        eret;
        logic        set_cp0;
        logic        read_cp0;
        logic [4:0]  cp0_addr;
        logic [31:0] badaddr;
        logic        exc_fetch;
        logic        exc_reserved;
        logic        exc_instruction;
        logic        exc_data;
        logic        adel;
        logic        ades;
        logic        sys;
        logic        bp;
        logic        ri;
        logic        ov;
        logic [4:0]  exccode;
    } bundle_t;

    state_t  state_q, state_d;
    logic    out_valid_q, out_valid_d;
    bundle_t bundle_q, bundle_d;

    logic data_access;
    logic data_misalign;
    logic exc_any;
    logic accept;

    // Byte accesses can never misalign; halfwords need bit 0 clear, words bits 1:0.
    assign data_access   = in_mem_rd | in_mem_wr;
    assign data_misalign = (in_mem_size == 2'd1) ? in_mem_addr[0]
                         : (in_mem_size[1] ? (|in_mem_addr[1:0]) : 1'b0);
    assign exc_any       = in_exc_fetch | in_ri | in_sys | in_bp
                         | (in_detect_of & in_alu_of)
                         | (data_access & data_misalign);

    // Priority-resolve the single winning cause and build the next bundle.
    always_comb begin
        bundle_d          = '0;
        bundle_d.pc       = in_pc;
        bundle_d.bd       = in_bd;
        bundle_d.eret     = in_eret;
        bundle_d.cp0_addr = in_cp0_addr;
        // CP0 side effects must not happen for an instruction that traps.
        bundle_d.set_cp0  = in_mtc0 & ~exc_any;
        bundle_d.read_cp0 = in_mfc0 & ~exc_any;
        if (in_exc_fetch) begin
            bundle_d.exc_fetch = 1'b1;
            bundle_d.adel      = 1'b1;
            bundle_d.exccode   = EXC_ADEL;
            bundle_d.badaddr   = in_pc;
        end else if (in_ri) begin
            bundle_d.exc_reserved = 1'b1;
            bundle_d.ri           = 1'b1;
            bundle_d.exccode      = EXC_RI;
        end else if (in_sys) begin
            bundle_d.exc_instruction = 1'b1;
            bundle_d.sys             = 1'b1;
            bundle_d.exccode         = EXC_SYS;
        end else if (in_bp) begin
            bundle_d.exc_instruction = 1'b1;
            bundle_d.bp              = 1'b1;
            bundle_d.exccode         = EXC_BP;
        end else if (in_detect_of & in_alu_of) begin
            bundle_d.exc_instruction = 1'b1;
            bundle_d.ov              = 1'b1;
            bundle_d.exccode         = EXC_OV;
        end else if (data_access & data_misalign) begin
            bundle_d.exc_data = 1'b1;
            bundle_d.badaddr  = in_mem_addr;
            if (in_mem_rd) begin
                bundle_d.adel    = 1'b1;
                bundle_d.exccode = EXC_ADEL;
            end else begin
                bundle_d.ades    = 1'b1;
                bundle_d.exccode = EXC_ADES;
            end
        end else begin
            bundle_d.exccode = EXC_NONE;
        end
    end

    // RUN/KILL next state, handshake, output-valid update and SRAM request gate.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b1;
        accept      = 1'b0;
        out_valid_d = out_valid_q;
        mem_req_ok  = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_ready = ~out_valid_q | out_ready;
                accept   = in_valid & in_ready & ~flush;
                if (accept & (exc_any | in_eret)) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                in_ready = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // A flush discards whatever EX holds and reopens the slice.
        if (flush) begin
            in_ready = 1'b1;
            accept   = 1'b0;
            state_d  = ST_RUN;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        mem_req_ok = accept & data_access & ~exc_any;
    end

    // State, valid and bundle registers; the bundle only changes on accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            bundle_q.pc <= RESET_PC;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                bundle_q <= bundle_d;
            end
        end
    end

    assign out_valid           = out_valid_q;
    assign out_pc              = bundle_q.pc;
    assign out_bd              = bundle_q.bd;
    assign out_eret            = bundle_q.eret;
    assign out_set_cp0         = bundle_q.set_cp0;
    assign out_read_cp0        = bundle_q.read_cp0;
    assign out_cp0_addr        = bundle_q.cp0_addr;
    assign out_badaddr         = bundle_q.badaddr;
    assign out_exc_fetch       = bundle_q.exc_fetch;
    assign out_exc_reserved    = bundle_q.exc_reserved;
    assign out_exc_instruction = bundle_q.exc_instruction;
    assign out_exc_data        = bundle_q.exc_data;
    assign out_adel            = bundle_q.adel;
    assign out_ades            = bundle_q.ades;
    assign out_sys             = bundle_q.sys;
    assign out_bp              = bundle_q.bp;
    assign out_ri              = bundle_q.ri;
    assign out_ov              = bundle_q.ov;
    assign out_exccode         = bundle_q.exccode;

endmodule

// File: tb/tb_ex_exception_stage.sv
// Randomized and directed bench for ex_exception_stage against a cause-table
// reference model.
module tb_ex_exception_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready;
    logic [31:0] in_pc;
    logic        in_bd, in_exc_fetch, in_ri, in_sys, in_bp, in_eret, in_mtc0, in_mfc0;
    logic [4:0]  in_cp0_addr;
    logic        in_detect_of, in_alu_of, in_mem_rd, in_mem_wr;
    logic [1:0]  in_mem_size;
    logic [31:0] in_mem_addr;
    logic        mem_req_ok, out_valid, out_ready;
    logic [31:0] out_pc, out_badaddr;
    logic        out_bd, out_eret, out_set_cp0, out_read_cp0;
    logic [4:0]  out_cp0_addr, out_exccode;
    logic        out_exc_fetch, out_exc_reserved, out_exc_instruction, out_exc_data;
    logic        out_adel, out_ades, out_sys, out_bp, out_ri, out_ov;

    ex_exception_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_bd(in_bd),
        .in_exc_fetch(in_exc_fetch), .in_ri(in_ri), .in_sys(in_sys), .in_bp(in_bp),
        .in_eret(in_eret), .in_mtc0(in_mtc0), .in_mfc0(in_mfc0), .in_cp0_addr(in_cp0_addr),
        .in_detect_of(in_detect_of), .in_alu_of(in_alu_of),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_mem_size(in_mem_size),
        .in_mem_addr(in_mem_addr), .mem_req_ok(mem_req_ok),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_bd(out_bd),
        .out_eret(out_eret), .out_set_cp0(out_set_cp0), .out_read_cp0(out_read_cp0),
        .out_cp0_addr(out_cp0_addr), .out_badaddr(out_badaddr),
        .out_exc_fetch(out_exc_fetch), .out_exc_reserved(out_exc_reserved),
        .out_exc_instruction(out_exc_instruction), .out_exc_data(out_exc_data),
        .out_adel(out_adel), .out_ades(out_ades), .out_sys(out_sys), .out_bp(out_bp),
        .out_ri(out_ri), .out_ov(out_ov), .out_exccode(out_exccode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        bd, eret, set_cp0, read_cp0;
        logic [4:0]  cp0_addr;
        logic [31:0] badaddr;
        logic        exc_fetch, exc_reserved, exc_instruction, exc_data;
        logic        adel, ades, sys, bp, ri, ov;
        logic [4:0]  exccode;
    } bundle_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        bd, fetch, ri, sys, bp, eret, mtc0, mfc0;
        logic [4:0]  cp0_addr;
        logic        detect_of, alu_of, rd, wr;
        logic [1:0]  size;
        logic [31:0] addr;
    } in_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: is a bundle pending, are we discarding, what is held.
    logic    m_valid, m_kill;
    bundle_t m_b;
    logic    exp_ready, exp_memok, obs_ready, obs_memok;

    function automatic bundle_t reset_bundle();
        bundle_t b = '0;
        b.pc = RESET_PC;
        return b;
    endfunction

    function automatic bundle_t dut_bundle();
        return {out_pc, out_bd, out_eret, out_set_cp0, out_read_cp0, out_cp0_addr, out_badaddr,
                out_exc_fetch, out_exc_reserved, out_exc_instruction, out_exc_data,
                out_adel, out_ades, out_sys, out_bp, out_ri, out_ov, out_exccode};
    endfunction

    // 0 none, 1 fetch AdEL, 2 RI, 3 Sys, 4 Bp, 5 Ov, 6 data AdEL, 7 data AdES
    function automatic int classify(in_t x);
        int mis;
        if (x.fetch) return 1;
        if (x.ri) return 2;
        if (x.sys) return 3;
        if (x.bp) return 4;
        if (x.detect_of && x.alu_of) return 5;
        if (x.rd || x.wr) begin
            if (x.size == 2'd0) mis = 0;
            else if (x.size == 2'd1) mis = (x.addr % 2 != 0) ? 1 : 0;
            else mis = (x.addr % 4 != 0) ? 1 : 0;
            if (mis != 0) return x.rd ? 6 : 7;
        end
        return 0;
    endfunction

    function automatic bundle_t expect_bundle(in_t x);
        bundle_t b = '0;
        int c = classify(x);
        b.pc = x.pc; b.bd = x.bd; b.eret = x.eret; b.cp0_addr = x.cp0_addr;
        b.set_cp0  = x.mtc0 && (c == 0);
        b.read_cp0 = x.mfc0 && (c == 0);
        case (c)
            1: begin b.exc_fetch = 1; b.adel = 1; b.exccode = 5'h04; b.badaddr = x.pc; end
            2: begin b.exc_reserved = 1; b.ri = 1; b.exccode = 5'h0a; end
            3: begin b.exc_instruction = 1; b.sys = 1; b.exccode = 5'h08; end
            4: begin b.exc_instruction = 1; b.bp = 1; b.exccode = 5'h09; end
            5: begin b.exc_instruction = 1; b.ov = 1; b.exccode = 5'h0c; end
            6: begin b.exc_data = 1; b.adel = 1; b.exccode = 5'h04; b.badaddr = x.addr; end
            7: begin b.exc_data = 1; b.ades = 1; b.exccode = 5'h05; b.badaddr = x.addr; end
            default: b.exccode = 5'h00;
        endcase
        return b;
    endfunction

    function automatic in_t nop();
        in_t x = '0;
        return x;
    endfunction

    function automatic in_t rand_in();
        in_t x = '0;
        int  m;
        x.valid     = ($urandom_range(0, 3) != 0);
        x.bd        = $urandom_range(0, 1) != 0;
        x.fetch     = ($urandom_range(0, 15) == 0);
        x.pc        = x.fetch ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFC);
        x.ri        = ($urandom_range(0, 19) == 0);
        x.sys       = ($urandom_range(0, 19) == 0);
        x.bp        = ($urandom_range(0, 19) == 0);
        x.eret      = ($urandom_range(0, 24) == 0);
        x.mtc0      = ($urandom_range(0, 5) == 0);
        x.mfc0      = ($urandom_range(0, 5) == 0);
        x.cp0_addr  = 5'($urandom);
        x.detect_of = ($urandom_range(0, 2) == 0);
        x.alu_of    = ($urandom_range(0, 2) == 0);
        m           = $urandom_range(0, 3);
        x.rd        = (m == 1);
        x.wr        = (m == 2);
        x.size      = 2'($urandom);
        x.addr      = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        return x;
    endfunction

    task automatic apply(input in_t x, input logic fl, input logic ordy);
        in_valid = x.valid; in_pc = x.pc; in_bd = x.bd; in_exc_fetch = x.fetch;
        in_ri = x.ri; in_sys = x.sys; in_bp = x.bp; in_eret = x.eret;
        in_mtc0 = x.mtc0; in_mfc0 = x.mfc0; in_cp0_addr = x.cp0_addr;
        in_detect_of = x.detect_of; in_alu_of = x.alu_of;
        in_mem_rd = x.rd; in_mem_wr = x.wr; in_mem_size = x.size; in_mem_addr = x.addr;
        flush = fl; out_ready = ordy;
    endtask

    task automatic model_reset();
        m_valid = 0; m_kill = 0; m_b = reset_bundle();
    endtask

    // One cycle: drive, sample combinational outputs mid-cycle, clock, advance model.
    task automatic tick(input in_t x, input logic fl, input logic ordy);
        logic acc;
        int   c;
        apply(x, fl, ordy);
        @(negedge clk);
        obs_ready = in_ready;
        obs_memok = mem_req_ok;
        c         = classify(x);
        exp_ready = fl || m_kill || !m_valid || ordy;
        acc       = x.valid && exp_ready && !m_kill && !fl;
        exp_memok = acc && (x.rd || x.wr) && (c == 0);
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_kill = 0;
        end else if (acc) begin
            m_valid = 1;
            m_b     = expect_bundle(x);
            if (c != 0 || x.eret) m_kill = 1;
        end else if (ordy) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++;
        if (dut_bundle() !== reset_bundle()) begin n_fail++; $display("FAIL reset_bundle: got %h want %h", dut_bundle(), reset_bundle()); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL reset_pc: got %h want bfc00000", out_pc); end
        n_checks++;
    endtask

    task automatic test_overflow();
        in_t x = nop();
        x.valid = 1; x.pc = 32'h1000; x.detect_of = 1; x.alu_of = 1;
        tick(x, 0, 1);
        $display("ov  pc=%h valid=%b code=%h ov=%b", out_pc, out_valid, out_exccode, out_ov);
        if (out_valid !== 1'b1 || out_ov !== 1'b1 || out_exc_instruction !== 1'b1 || out_exccode !== 5'h0c) begin
            n_fail++; $display("FAIL ov_flags: got v=%b ov=%b ei=%b code=%h want 1 1 1 0c", out_valid, out_ov, out_exc_instruction, out_exccode);
        end
        n_checks++;
        if (dut_bundle() !== m_b) begin n_fail++; $display("FAIL ov_bundle: got %h want %h", dut_bundle(), m_b); end
        n_checks++;
        x = nop(); x.valid = 1; x.pc = 32'h1004; x.rd = 1; x.size = 2; x.addr = 32'h2000;
        tick(x, 0, 1);
        $display("kill pc=1004 ready=%b memok=%b valid=%b", obs_ready, obs_memok, out_valid);
        if (obs_ready !== 1'b1 || obs_memok !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ov_kill: got rdy=%b memok=%b v=%b want 1 0 0", obs_ready, obs_memok, out_valid);
        end
        n_checks++;
        tick(nop(), 1, 1);
    endtask

    task automatic test_data_misalign();
        in_t x = nop();
        x.valid = 1; x.pc = 32'h1100; x.rd = 1; x.size = 2; x.addr = 32'h2002;
        tick(x, 0, 1);
        $display("lw  addr=2002 memok=%b code=%h bad=%h", obs_memok, out_exccode, out_badaddr);
        if (obs_memok !== 1'b0 || out_adel !== 1'b1 || out_badaddr !== 32'h2002 || out_exccode !== 5'h04) begin
            n_fail++; $display("FAIL lw_adel: got memok=%b adel=%b bad=%h code=%h want 0 1 2002 04", obs_memok, out_adel, out_badaddr, out_exccode);
        end
        n_checks++;
        tick(nop(), 1, 1);
        x = nop(); x.valid = 1; x.pc = 32'h1104; x.wr = 1; x.size = 1; x.addr = 32'h3001;
        tick(x, 0, 1);
        $display("sh  addr=3001 memok=%b code=%h bad=%h", obs_memok, out_exccode, out_badaddr);
        if (obs_memok !== 1'b0 || out_ades !== 1'b1 || out_exc_data !== 1'b1 || out_exccode !== 5'h05 || out_badaddr !== 32'h3001) begin
            n_fail++; $display("FAIL sh_ades: got memok=%b ades=%b ed=%b code=%h bad=%h want 0 1 1 05 3001", obs_memok, out_ades, out_exc_data, out_exccode, out_badaddr);
        end
        n_checks++;
        tick(nop(), 1, 1);
        x = nop(); x.valid = 1; x.pc = 32'h1108; x.rd = 1; x.size = 1; x.addr = 32'h3002;
        tick(x, 0, 1);
        $display("lh  addr=3002 memok=%b code=%h", obs_memok, out_exccode);
        if (obs_memok !== 1'b1 || out_exccode !== 5'h00 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL lh_ok: got memok=%b code=%h v=%b want 1 00 1", obs_memok, out_exccode, out_valid);
        end
        n_checks++;
        x = nop(); x.valid = 1; x.pc = 32'h110c; x.wr = 1; x.size = 0; x.addr = 32'h3003;
        tick(x, 0, 1);
        $display("sb  addr=3003 memok=%b code=%h", obs_memok, out_exccode);
        if (obs_memok !== 1'b1 || dut_bundle() !== m_b) begin
            n_fail++; $display("FAIL sb_ok: got memok=%b bundle=%h want 1 %h", obs_memok, dut_bundle(), m_b);
        end
        n_checks++;
        tick(nop(), 0, 1);
    endtask

    task automatic test_priority();
        in_t x = nop();
        x.valid = 1; x.pc = 32'h1001; x.fetch = 1; x.ri = 1; x.rd = 1; x.size = 2; x.addr = 32'h2002;
        tick(x, 0, 1);
        $display("pri fetch+ri+lw code=%h bad=%h", out_exccode, out_badaddr);
        if (out_exc_fetch !== 1'b1 || out_adel !== 1'b1 || out_ri !== 1'b0 || out_exc_reserved !== 1'b0 ||
            out_exc_data !== 1'b0 || out_badaddr !== 32'h1001 || out_exccode !== 5'h04 || obs_memok !== 1'b0) begin
            n_fail++; $display("FAIL pri_fetch: got %h want fetch/adel only, bad=1001", dut_bundle());
        end
        n_checks++;
        tick(nop(), 1, 1);
        x = nop(); x.valid = 1; x.pc = 32'h1200; x.ri = 1; x.sys = 1; x.bp = 1;
        tick(x, 0, 1);
        if (out_ri !== 1'b1 || out_sys !== 1'b0 || out_bp !== 1'b0 || out_exccode !== 5'h0a) begin
            n_fail++; $display("FAIL pri_ri: got ri=%b sys=%b bp=%b code=%h want 1 0 0 0a", out_ri, out_sys, out_bp, out_exccode);
        end
        n_checks++;
        tick(nop(), 1, 1);
        x = nop(); x.valid = 1; x.pc = 32'h1204; x.bp = 1; x.detect_of = 1; x.alu_of = 1; x.mtc0 = 1;
        tick(x, 0, 1);
        if (out_bp !== 1'b1 || out_ov !== 1'b0 || out_exccode !== 5'h09 || out_set_cp0 !== 1'b0) begin
            n_fail++; $display("FAIL pri_bp: got bp=%b ov=%b code=%h setcp0=%b want 1 0 09 0", out_bp, out_ov, out_exccode, out_set_cp0);
        end
        n_checks++;
        tick(nop(), 1, 1);
        x = nop(); x.valid = 1; x.pc = 32'h1208; x.detect_of = 1; x.alu_of = 1; x.wr = 1; x.size = 3; x.addr = 32'h4001;
        tick(x, 0, 1);
        if (dut_bundle() !== m_b || out_exccode !== 5'h0c || out_ades !== 1'b0) begin
            n_fail++; $display("FAIL pri_ov: got %h want %h", dut_bundle(), m_b);
        end
        n_checks++;
        tick(nop(), 1, 1);
    endtask

    task automatic test_kill();
        in_t x = nop();
        x.valid = 1; x.pc = 32'h1300; x.sys = 1;
        tick(x, 0, 1);
        for (int i = 0; i < 3; i++) begin
            x = nop(); x.valid = 1; x.pc = 32'h1304 + 32'(4 * i); x.rd = 1; x.size = 2; x.addr = 32'h5000;
            tick(x, 0, 1);
            $display("kill%0d ready=%b memok=%b valid=%b", i, obs_ready, obs_memok, out_valid);
            if (obs_ready !== 1'b1 || obs_memok !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL kill_discard%0d: got rdy=%b memok=%b v=%b want 1 0 0", i, obs_ready, obs_memok, out_valid);
            end
            n_checks++;
        end
        tick(nop(), 1, 1);
        x = nop(); x.valid = 1; x.pc = 32'h1400; x.rd = 1; x.size = 2; x.addr = 32'h5004;
        tick(x, 0, 1);
        $display("run pc=%h memok=%b valid=%b", out_pc, obs_memok, out_valid);
        if (obs_memok !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h1400) begin
            n_fail++; $display("FAIL kill_resume: got memok=%b v=%b pc=%h want 1 1 1400", obs_memok, out_valid, out_pc);
        end
        n_checks++;
        tick(nop(), 0, 1);
    endtask

    task automatic test_stall();
        bundle_t snap;
        in_t     x = nop();
        x.valid = 1; x.pc = 32'h1500; x.mtc0 = 1; x.cp0_addr = 5'd12;
        tick(x, 0, 1);
        snap = expect_bundle(x);
        for (int i = 0; i < 4; i++) begin
            x = nop(); x.valid = 1; x.pc = 32'h1504; x.rd = 1; x.size = 2; x.addr = 32'h6000;
            tick(x, 0, 0);
            $display("stall%0d ready=%b valid=%b pc=%h", i, obs_ready, out_valid, out_pc);
            if (obs_ready !== 1'b0 || obs_memok !== 1'b0 || out_valid !== 1'b1 || dut_bundle() !== snap) begin
                n_fail++; $display("FAIL stall_hold%0d: got rdy=%b memok=%b v=%b b=%h want 0 0 1 %h", i, obs_ready, obs_memok, out_valid, dut_bundle(), snap);
            end
            n_checks++;
        end
        x = nop(); x.valid = 1; x.pc = 32'h1508; x.ri = 1;
        tick(x, 1, 0);
        $display("flush+exc ready=%b valid=%b pc=%h", obs_ready, out_valid, out_pc);
        if (obs_ready !== 1'b1 || obs_memok !== 1'b0 || out_valid !== 1'b0 || dut_bundle() !== snap) begin
            n_fail++; $display("FAIL stall_flush: got rdy=%b memok=%b v=%b b=%h want 1 0 0 %h", obs_ready, obs_memok, out_valid, dut_bundle(), snap);
        end
        n_checks++;
        x = nop(); x.valid = 1; x.pc = 32'h150c; x.wr = 1; x.size = 2; x.addr = 32'h6004;
        tick(x, 0, 1);
        if (obs_memok !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h150c) begin
            n_fail++; $display("FAIL stall_run: got memok=%b v=%b pc=%h want 1 1 150c", obs_memok, out_valid, out_pc);
        end
        n_checks++;
        tick(nop(), 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_t  x    = rand_in();
            logic fl   = ($urandom_range(0, 5) == 0);
            logic ordy = ($urandom_range(0, 3) != 0);
            tick(x, fl, ordy);
            $display("rnd%0d v=%b fl=%b ordy=%b rdy=%b memok=%b out_v=%b code=%h", i, x.valid, fl, ordy, obs_ready, obs_memok, out_valid, out_exccode);
            if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready%0d: got %b want %b", i, obs_ready, exp_ready); end
            n_checks++;
            if (obs_memok !== exp_memok) begin n_fail++; $display("FAIL rnd_memok%0d: got %b want %b", i, obs_memok, exp_memok); end
            n_checks++;
            if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid%0d: got %b want %b", i, out_valid, m_valid); end
            n_checks++;
            if (dut_bundle() !== m_b) begin n_fail++; $display("FAIL rnd_bundle%0d: got %h want %h", i, dut_bundle(), m_b); end
            n_checks++;
        end
    endtask

    task automatic test_async_reset();
        in_t x = nop();
        x.valid = 1; x.pc = 32'h1600; x.bp = 1;
        tick(x, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        $display("async reset valid=%b pc=%h", out_valid, out_pc);
        if (out_valid !== 1'b0 || dut_bundle() !== reset_bundle()) begin
            n_fail++; $display("FAIL async_reset: got v=%b b=%h want 0 %h", out_valid, dut_bundle(), reset_bundle());
        end
        n_checks++;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        x = nop(); x.valid = 1; x.pc = 32'h1700; x.rd = 1; x.size = 0; x.addr = 32'h7001;
        tick(x, 0, 1);
        if (obs_memok !== 1'b1 || out_valid !== 1'b1 || dut_bundle() !== m_b) begin
            n_fail++; $display("FAIL async_resume: got memok=%b v=%b b=%h want 1 1 %h", obs_memok, out_valid, dut_bundle(), m_b);
        end
        n_checks++;
        tick(nop(), 0, 1);
    endtask

    initial begin
        resetn = 1'b0;
        apply(nop(), 1'b0, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        test_overflow();
        test_data_misalign();
        test_priority();
        test_kill();
        test_stall();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
